// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: multi-lane register-file commit, forwarding, store buffer, ECALL sequencing.
// Define WB_COMMIT_BYPASS_EN to return same-cycle committing writes on the read ports.
module wb_commit_unit #(
    parameter int XLEN       = 64,
    parameter int LANES      = 2,
    parameter int SBUF_DEPTH = 4,
    parameter int RD_PORTS   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     advance_i,
    input  logic [LANES-1:0]         wb_valid_i,
    input  logic [LANES*5-1:0]       wb_rd_i,
    input  logic [LANES-1:0]         wb_sel_i,
    input  logic [LANES*XLEN-1:0]    wb_alu_i,
    input  logic [LANES*XLEN-1:0]    wb_load_i,
    input  logic                     ecall_i,
    input  logic                     pw_valid_i,
    input  logic [XLEN-1:0]          pw_addr_i,
    input  logic [XLEN-1:0]          pw_data_i,
    input  logic [3:0]               pw_size_i,
    output logic                     sbuf_full_o,
    output logic                     mem_wr_valid_o,
    output logic [XLEN-1:0]          mem_wr_addr_o,
    output logic [XLEN-1:0]          mem_wr_data_o,
    output logic [3:0]               mem_wr_size_o,
    input  logic                     mem_wr_ready_i,
    output logic                     ecall_req_o,
    output logic [8*XLEN-1:0]        ecall_args_o,
    input  logic                     ecall_ack_i,
    input  logic [XLEN-1:0]          ecall_ret_i,
    output logic                     ecall_done_o,
    output logic                     busy_o,
    output logic [LANES-1:0]         fwd_valid_o,
    output logic [LANES*5-1:0]       fwd_rd_o,
    output logic [LANES*XLEN-1:0]    fwd_val_o,
    input  logic [RD_PORTS*5-1:0]    rf_raddr_i,
    output logic [RD_PORTS*XLEN-1:0] rf_rdata_o
);
    localparam int PW = $clog2(SBUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REQ, S_DONE} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0] rf_q [32];
    logic            commit;
    logic [LANES-1:0][XLEN-1:0] lane_val;
    logic [LANES-1:0]           lane_we;
    logic [LANES-1:0]           lane_last;

    assign commit = advance_i && (state_q == S_IDLE);

    // lane_last marks the lane whose write actually lands (highest index wins on rd collisions)
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_val[l]  = wb_sel_i[l] ? wb_load_i[l*XLEN +: XLEN] : wb_alu_i[l*XLEN +: XLEN];
            lane_we[l]   = commit && wb_valid_i[l] && (wb_rd_i[l*5 +: 5] != 5'd0);
        end
        for (int l = 0; l < LANES; l++) begin
            lane_last[l] = lane_we[l];
            for (int h = l + 1; h < LANES; h++)
                if (lane_we[h] && (wb_rd_i[h*5 +: 5] == wb_rd_i[l*5 +: 5])) lane_last[l] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++)
                if (lane_last[l]) rf_q[wb_rd_i[l*5 +: 5]] <= lane_val[l];
            if (state_q == S_REQ && ecall_ack_i) rf_q[10] <= ecall_ret_i;
        end
    end

    logic [LANES-1:0]      fwd_valid_q;
    logic [LANES*5-1:0]    fwd_rd_q;
    logic [LANES*XLEN-1:0] fwd_val_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_valid_q <= '0;
            fwd_rd_q    <= '0;
            fwd_val_q   <= '0;
        end else begin
            fwd_valid_q <= lane_last;
            for (int l = 0; l < LANES; l++) begin
                if (lane_last[l]) begin
                    fwd_rd_q[l*5 +: 5]        <= wb_rd_i[l*5 +: 5];
                    fwd_val_q[l*XLEN +: XLEN] <= lane_val[l];
                end
            end
        end
    end

    assign fwd_valid_o = fwd_valid_q;
    assign fwd_rd_o    = fwd_rd_q;
    assign fwd_val_o   = fwd_val_q;

    // Store buffer: circular FIFO, storage itself needs no reset since outputs are masked by valid
    logic [XLEN-1:0] sb_addr_q [SBUF_DEPTH];
    logic [XLEN-1:0] sb_data_q [SBUF_DEPTH];
    logic [3:0]      sb_size_q [SBUF_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [PW:0]     cnt_q;
    logic            sb_full, sb_empty, enq, deq;

    assign sb_full  = (cnt_q == (PW+1)'(SBUF_DEPTH));
    assign sb_empty = (cnt_q == '0);
    assign deq      = !sb_empty && mem_wr_ready_i;
    assign enq      = pw_valid_i && commit && (!sb_full || deq);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + 1'b1;
            if (deq) rptr_q <= rptr_q + 1'b1;
            if (enq && !deq) cnt_q <= cnt_q + 1'b1;
            else if (deq && !enq) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            sb_addr_q[wptr_q] <= pw_addr_i;
            sb_data_q[wptr_q] <= pw_data_i;
            sb_size_q[wptr_q] <= pw_size_i;
        end
    end

    assign sbuf_full_o    = sb_full;
    assign mem_wr_valid_o = !sb_empty;
    assign mem_wr_addr_o  = sb_empty ? '0 : sb_addr_q[rptr_q];
    assign mem_wr_data_o  = sb_empty ? '0 : sb_data_q[rptr_q];
    assign mem_wr_size_o  = sb_empty ? '0 : sb_size_q[rptr_q];

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        busy_o       = (state_q != S_IDLE);
        ecall_req_o  = 1'b0;
        ecall_done_o = 1'b0;
        ecall_args_o = '0;
        case (state_q)
            S_IDLE:  if (ecall_i && commit) state_d = S_DRAIN;
            S_DRAIN: if (sb_empty) state_d = S_REQ;
            S_REQ: begin
                ecall_req_o = 1'b1;
                for (int k = 0; k < 8; k++) ecall_args_o[k*XLEN +: XLEN] = rf_q[10+k];
                if (ecall_ack_i) state_d = S_DONE;
            end
            S_DONE: begin
                ecall_done_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rf_rdata_o = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rf_rdata_o[p*XLEN +: XLEN] = rf_q[rf_raddr_i[p*5 +: 5]];
`ifdef WB_COMMIT_BYPASS_EN
            for (int l = 0; l < LANES; l++)
                if (lane_we[l] && (wb_rd_i[l*5 +: 5] == rf_raddr_i[p*5 +: 5]))
                    rf_rdata_o[p*XLEN +: XLEN] = lane_val[l];
`endif
            if (rf_raddr_i[p*5 +: 5] == 5'd0) rf_rdata_o[p*XLEN +: XLEN] = '0;
        end
    end

endmodule
